// File: rtl/sys_defs.sv
// sys_defs: shared bus command, memory size, FU packet and memory tag types
package sys_defs;
  localparam int XLEN = 32;
  localparam int MEM_TAG_W = 4;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;
  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;
  typedef struct packed {
    BUS_COMMAND      cmd;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    MEM_SIZE         size;
  } FU_MEM_PACKET;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-client (store/load) selector, round-robin or store-first fixed priority
// ports: clk_i/rst_ni clock and async active-low reset; store_req_i/load_req_i requests;
//        update_i records the current winner; grant_load_o high when load wins (store otherwise)
module rr_arbiter2 #(
  parameter bit RR_ARB = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic store_req_i,
  input  logic load_req_i,
  input  logic update_i,
  output logic grant_load_o
);
  logic last_load_q;
  // a last grant of "load" is the reset value so store wins the first contest
  always_comb grant_load_o = load_req_i & (~store_req_i | (RR_ARB & ~last_load_q));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) last_load_q <= 1'b1;
    else if (update_i) last_load_q <= grant_load_o;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between a load and a store client
// ports: clk_i/rst_ni clock and async active-low reset; load_/store_ req and packet inputs;
//        flush_i squashes the load; Dmem2proc_* memory accept tag, return data and tag;
//        proc2Dmem_* bus command/addr/data/size; load_ack_o/store_ack_o done pulses;
//        load_data_o raw returned data; busy_o high outside IDLE
module dmem_arbiter
  import sys_defs::*;
#(
  parameter bit RR_ARB = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_req_i,
  input  FU_MEM_PACKET         load_mem_packet_i,
  input  logic                 store_req_i,
  input  FU_MEM_PACKET         store_mem_packet_i,
  input  logic                 flush_i,
  input  logic [MEM_TAG_W-1:0] Dmem2proc_response_i,
  input  logic [XLEN-1:0]      Dmem2proc_data_i,
  input  logic [MEM_TAG_W-1:0] Dmem2proc_tag_i,
  output BUS_COMMAND           proc2Dmem_command_o,
  output logic [XLEN-1:0]      proc2Dmem_addr_o,
  output logic [XLEN-1:0]      proc2Dmem_data_o,
  output MEM_SIZE              proc2Dmem_size_o,
  output logic                 load_ack_o,
  output logic                 store_ack_o,
  output logic [XLEN-1:0]      load_data_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, ACK} state_e;
  state_e               state_q, state_d;
  FU_MEM_PACKET         pkt_q, pkt_d;
  logic                 is_load_q, is_load_d;
  logic                 squash_q, squash_d;
  logic [MEM_TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]      load_data_q, load_data_d;
  logic                 load_eff, grant_load, grant;
  logic                 drop;
  // a load raised together with flush is already squashed and never competes
  always_comb load_eff = load_req_i & ~flush_i;
  always_comb grant = (state_q == IDLE) & (store_req_i | load_eff);
  always_comb drop = squash_q | flush_i;
  rr_arbiter2 #(.RR_ARB(RR_ARB)) u_rr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .store_req_i  (store_req_i),
    .load_req_i   (load_eff),
    .update_i     (grant),
    .grant_load_o (grant_load)
  );
  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    is_load_d   = is_load_q;
    squash_d    = squash_q;
    tag_d       = tag_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d   = ISSUE;
        is_load_d = grant_load;
        pkt_d     = grant_load ? load_mem_packet_i : store_mem_packet_i;
      end
      ISSUE:
        if (is_load_q & flush_i) state_d = IDLE;
        else if (Dmem2proc_response_i != '0) begin
          tag_d   = Dmem2proc_response_i;
          state_d = is_load_q ? WAIT_DATA : ACK;
        end
      WAIT_DATA: begin
        // a squashed load still waits for its tag so memory is drained
        squash_d = drop;
        if (tag_q != '0 && Dmem2proc_tag_i == tag_q) begin
          state_d     = ACK;
          load_data_d = drop ? load_data_q : Dmem2proc_data_i;
        end
      end
      default: begin
        state_d  = IDLE;
        tag_d    = '0;
        squash_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      is_load_q   <= 1'b0;
      squash_q    <= 1'b0;
      tag_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      is_load_q   <= is_load_d;
      squash_q    <= squash_d;
      tag_q       <= tag_d;
      load_data_q <= load_data_d;
    end
  // a load being flushed in ISSUE must not put a command on the bus that cycle
  always_comb proc2Dmem_command_o = (state_q == ISSUE && !(is_load_q && flush_i)) ? pkt_q.cmd : BUS_NONE;
  always_comb proc2Dmem_addr_o = pkt_q.addr;
  always_comb proc2Dmem_data_o = pkt_q.data;
  always_comb proc2Dmem_size_o = pkt_q.size;
  always_comb load_ack_o = (state_q == ACK) & is_load_q & ~drop;
  always_comb store_ack_o = (state_q == ACK) & ~is_load_q;
  always_comb load_data_o = load_data_q;
  always_comb busy_o = state_q != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter (vector table, directed corners, random vs model)
module tb_dmem_arbiter;
  import sys_defs::*;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic load_req, store_req, flush, fp_load_req, fp_store_req;
  FU_MEM_PACKET load_pkt, store_pkt;
  logic [3:0] resp, mtag;
  logic [31:0] mdata;
  BUS_COMMAND cmd, fp_cmd;
  MEM_SIZE size, fp_size;
  logic [31:0] addr, wdata, ldata, fp_addr, fp_wdata, fp_ldata;
  logic lack, sack, busy, fp_lack, fp_sack, fp_busy;
  int n_tests = 0;
  int n_fail = 0;

  dmem_arbiter #(.RR_ARB(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .load_req_i(load_req), .load_mem_packet_i(load_pkt),
    .store_req_i(store_req), .store_mem_packet_i(store_pkt),
    .flush_i(flush), .Dmem2proc_response_i(resp), .Dmem2proc_data_i(mdata), .Dmem2proc_tag_i(mtag),
    .proc2Dmem_command_o(cmd), .proc2Dmem_addr_o(addr), .proc2Dmem_data_o(wdata), .proc2Dmem_size_o(size),
    .load_ack_o(lack), .store_ack_o(sack), .load_data_o(ldata), .busy_o(busy)
  );
  dmem_arbiter #(.RR_ARB(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .load_req_i(fp_load_req), .load_mem_packet_i(load_pkt),
    .store_req_i(fp_store_req), .store_mem_packet_i(store_pkt),
    .flush_i(flush), .Dmem2proc_response_i(resp), .Dmem2proc_data_i(mdata), .Dmem2proc_tag_i(mtag),
    .proc2Dmem_command_o(fp_cmd), .proc2Dmem_addr_o(fp_addr), .proc2Dmem_data_o(fp_wdata), .proc2Dmem_size_o(fp_size),
    .load_ack_o(fp_lack), .store_ack_o(fp_sack), .load_data_o(fp_ldata), .busy_o(fp_busy)
  );

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
    MEM_SIZE     size;
    int          rejects;
    logic [3:0]  rtag;
    int          delay;
    logic [31:0] rdata;
    BUS_COMMAND  exp_cmd;
    int          exp_issue;
    logic [31:0] exp_ldata;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic FU_MEM_PACKET mk(input BUS_COMMAND c, input logic [31:0] a, input logic [31:0] d, input MEM_SIZE s);
    return '{cmd: c, addr: a, data: d, size: s};
  endfunction

  task automatic idle_inputs();
    load_req = 0; store_req = 0; flush = 0; fp_load_req = 0; fp_store_req = 0;
    resp = 0; mtag = 0; mdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int issues = 0, bad = 0, lacks = 0, sacks = 0, acc = -1, fin = -1, ackc = -1, rej = 0;
    if (v.st) begin store_pkt = mk(BUS_STORE, v.addr, v.data, v.size); store_req = 1; end
    else begin load_pkt = mk(BUS_LOAD, v.addr, v.data, v.size); load_req = 1; end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd != BUS_NONE) begin
        issues++;
        if (cmd !== v.exp_cmd || addr !== v.addr || wdata !== v.data || size !== v.size) bad++;
      end
      if (lack) begin lacks++; ackc = i; load_req = 0; end
      if (sack) begin sacks++; ackc = i; store_req = 0; end
      resp = 0; mtag = 0;
      if (cmd != BUS_NONE) begin
        if (rej < v.rejects) rej++;
        else begin resp = v.rtag; acc = i; if (v.st) fin = i; end
      end
      if (!v.st && acc >= 0 && i == acc + v.delay) begin mtag = v.rtag; mdata = v.rdata; fin = i; end
    end
    chk($sformatf("vec%0d_issue_cycles", k), issues, v.exp_issue);
    chk($sformatf("vec%0d_bus_fields", k), bad, 0);
    chk($sformatf("vec%0d_load_acks", k), lacks, v.st ? 0 : 1);
    chk($sformatf("vec%0d_store_acks", k), sacks, v.st ? 1 : 0);
    chk($sformatf("vec%0d_ack_latency", k), ackc - fin, 1);
    chk($sformatf("vec%0d_load_data", k), ldata, v.exp_ldata);
    chk($sformatf("vec%0d_idle_after", k), busy, 0);
  endtask

  task automatic serve_one(input string name, input logic [31:0] rd, output BUS_COMMAND first);
    bit done = 0;
    int acc = -1;
    first = BUS_NONE;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (lack) begin load_req = 0; done = 1; end
      if (sack) begin store_req = 0; done = 1; end
      resp = 0; mtag = 0;
      if (cmd != BUS_NONE) begin if (first == BUS_NONE) first = cmd; resp = 4'd4; acc = i; end
      else if (busy && !done && acc >= 0) begin mtag = 4'd4; mdata = rd; end
    end
    chk({name, "_completed"}, done, 1);
  endtask

  task automatic rand_test();
    bit last_load = 1, in_txn = 0, issuing = 0, waiting = 0, idle_prev = 1, tl = 0, wl;
    int exp_ack = 0, cur_ack, wcnt = 0;
    logic [3:0] otag = 0;
    logic [31:0] odata = 0;
    FU_MEM_PACKET wp;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (idle_prev && (load_req || store_req)) begin
        wl = load_req && (!store_req || !last_load);
        wp = wl ? load_pkt : store_pkt;
        last_load = wl; tl = wl; in_txn = 1; issuing = 1;
        chk("rand_addr", addr, wp.addr);
        chk("rand_wdata", wdata, wp.data);
        chk("rand_size", size, wp.size);
      end
      chk("rand_cmd", cmd, issuing ? (tl ? BUS_LOAD : BUS_STORE) : BUS_NONE);
      chk("rand_load_ack", lack, exp_ack == 1);
      chk("rand_store_ack", sack, exp_ack == 2);
      if (exp_ack == 1) chk("rand_load_data", ldata, odata);
      chk("rand_busy", busy, in_txn);
      cur_ack = exp_ack; exp_ack = 0;
      idle_prev = !in_txn;
      if (cur_ack != 0) in_txn = 0;
      if (cur_ack == 1) load_req = 0;
      else if (!load_req && $urandom_range(2) == 0) begin
        load_pkt = mk(BUS_LOAD, $urandom, $urandom, MEM_SIZE'(2'($urandom_range(3)))); load_req = 1;
      end
      if (cur_ack == 2) store_req = 0;
      else if (!store_req && $urandom_range(2) == 0) begin
        store_pkt = mk(BUS_STORE, $urandom, $urandom, MEM_SIZE'(2'($urandom_range(3)))); store_req = 1;
      end
      resp = 4'($urandom); mtag = 4'($urandom); mdata = $urandom;
      if (issuing) begin
        resp = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
        if (resp != 0) begin
          otag = resp; issuing = 0;
          if (tl) begin waiting = 1; wcnt = $urandom_range(3, 1); end
          else exp_ack = 2;
        end
      end else if (waiting) begin
        wcnt--;
        if (wcnt == 0) begin mtag = otag; odata = mdata; exp_ack = 1; waiting = 0; end
        else while (mtag == otag) mtag = 4'($urandom);
      end
    end
  endtask

  initial begin
    BUS_COMMAND c1, c2, c3, c4, c5;
    int n, stores, loads;
    vecs[0] = '{1'b0, 32'h100, 32'h0, WORD, 0, 4'd3, 2, 32'hDEADBEEF, BUS_LOAD, 1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h200, 32'h55, WORD, 3, 4'd5, 0, 32'h0, BUS_STORE, 4, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h304, 32'h0, HALF, 1, 4'd15, 1, 32'h12345678, BUS_LOAD, 2, 32'h12345678};
    vecs[3] = '{1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, BYTE, 0, 4'd1, 0, 32'h0, BUS_STORE, 1, 32'h12345678};
    load_pkt = '0; store_pkt = '0;
    rst_n = 0;
    idle_inputs();
    #1;
    chk("reset_cmd", cmd, BUS_NONE);
    chk("reset_addr", addr, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_size", size, 0);
    chk("reset_load_ack", lack, 0);
    chk("reset_store_ack", sack, 0);
    chk("reset_load_data", ldata, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) run_vec(k, vecs[k]);

    do_reset();
    load_pkt = mk(BUS_LOAD, 32'h40, 32'h0, WORD);
    store_pkt = mk(BUS_STORE, 32'h80, 32'h99, WORD);
    load_req = 1; store_req = 1;
    serve_one("rr1", 32'h1111, c1);
    serve_one("rr2", 32'h2222, c2);
    chk("rr_first_store", c1, BUS_STORE);
    chk("rr_second_load", c2, BUS_LOAD);
    chk("rr_load_data", ldata, 32'h2222);
    load_req = 1; store_req = 1;
    serve_one("rr3", 32'h3333, c3);
    store_req = 1;
    serve_one("rr4", 32'h4444, c4);
    serve_one("rr5", 32'h5555, c5);
    chk("rr_third_store", c3, BUS_STORE);
    chk("rr_fourth_load", c4, BUS_LOAD);
    chk("rr_fifth_store", c5, BUS_STORE);

    do_reset();
    fp_load_req = 1; fp_store_req = 1; resp = 4'd1;
    stores = 0; loads = 0; n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fp_cmd == BUS_STORE) stores++;
      if (fp_cmd == BUS_LOAD) loads++;
      if (fp_sack) n++;
    end
    chk("fp_no_load_grant", loads, 0);
    chk("fp_repeated_store_grants", stores >= 3, 1);
    chk("fp_store_acks", n >= 3, 1);

    do_reset();
    load_pkt = mk(BUS_LOAD, 32'h500, 32'h0, WORD); load_req = 1;
    @(negedge clk);
    chk("wt_issue", cmd, BUS_LOAD);
    resp = 4'd2;
    @(negedge clk);
    resp = 0; mtag = 4'd7; mdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("wt_wrong_no_ack", lack, 0);
    chk("wt_wrong_busy", busy, 1);
    chk("wt_wrong_no_capture", ldata, 0);
    mtag = 4'd2; mdata = 32'h600D600D;
    @(negedge clk);
    chk("wt_right_ack", lack, 1);
    chk("wt_right_data", ldata, 32'h600D600D);
    load_req = 0; mtag = 0;
    @(negedge clk);
    chk("wt_ack_one_cycle", lack, 0);
    chk("wt_idle", busy, 0);

    do_reset();
    load_pkt = mk(BUS_LOAD, 32'h600, 32'h0, WORD); load_req = 1;
    @(negedge clk);
    chk("fw_issue", cmd, BUS_LOAD);
    resp = 4'd6;
    @(negedge clk);
    resp = 0; flush = 1; load_req = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      flush = 0; mtag = 0;
      if (i == 0) chk("fw_still_waiting", busy, 1);
      if (i == 1) begin mtag = 4'd6; mdata = 32'h77; end
      if (lack) n++;
    end
    chk("fw_no_load_ack", n, 0);
    chk("fw_idle", busy, 0);
    chk("fw_data_discarded", ldata, 0);
    store_pkt = mk(BUS_STORE, 32'h640, 32'hAB, WORD); store_req = 1;
    serve_one("fw_next", 32'h0, c1);
    chk("fw_next_granted", c1, BUS_STORE);

    do_reset();
    load_pkt = mk(BUS_LOAD, 32'h680, 32'h0, WORD); load_req = 1;
    @(negedge clk);
    chk("fi_issue", cmd, BUS_LOAD);
    flush = 1; resp = 4'd3;
    #1;
    chk("fi_cmd_masked", cmd, BUS_NONE);
    load_req = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flush = 0; resp = 0;
      if (cmd != BUS_NONE || lack || busy) n++;
    end
    chk("fi_dropped", n, 0);
    load_req = 1; flush = 1;
    @(negedge clk);
    chk("fidle_no_grant", busy, 0);
    load_req = 0; flush = 0;

    do_reset();
    load_pkt = mk(BUS_LOAD, 32'h700, 32'h0, WORD); load_req = 1;
    @(negedge clk);
    chk("rst_issue", cmd, BUS_LOAD);
    rst_n = 0; resp = 4'd3;
    #1;
    chk("rst_cmd_none", cmd, BUS_NONE);
    chk("rst_addr_zero", addr, 0);
    chk("rst_busy_zero", busy, 0);
    load_req = 0;
    @(negedge clk);
    rst_n = 1; resp = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mtag = 4'd3; mdata = 32'h99;
      if (lack || sack || cmd != BUS_NONE) n++;
    end
    chk("rst_late_tag_ignored", n, 0);

    do_reset();
    rand_test();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: RR_ARB, default 1; 1 = round-robin between load and store clients, 0 = fixed priority with store first.
REQ-002 clock  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 load_req  in  1  load FU request, held high until load_ack is sampled.
REQ-005 load_mem_packet  in  FU_MEM_PACKET  load command, address, data and size.
REQ-006 store_req  in  1  store FU request, held high until store_ack is sampled.
REQ-007 store_mem_packet  in  FU_MEM_PACKET  store command, address, data and size.
REQ-008 flush  in  1  squash; the in-flight load result is discarded.
REQ-009 Dmem2proc_response  in  4  memory accept tag; 0 = rejected.
REQ-010 Dmem2proc_data  in  XLEN  memory return data.
REQ-011 Dmem2proc_tag  in  4  tag of returning data; 0 = none.
REQ-012 proc2Dmem_command  out  BUS_COMMAND  BUS_NONE, BUS_LOAD or BUS_STORE.
REQ-013 proc2Dmem_addr  out  XLEN  latched address.
REQ-014 proc2Dmem_data  out  XLEN  latched store data.
REQ-015 proc2Dmem_size  out  MEM_SIZE  latched size.
REQ-016 load_ack  out  1  one-cycle pulse; load done and load_data valid.
REQ-017 store_ack  out  1  one-cycle pulse; store accepted by memory.
REQ-018 load_data  out  XLEN  registered raw memory data; extension is done downstream.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT_DATA, ACK.
REQ-021 IDLE, any request high: select a winner per RR_ARB, latch the winner's packet and its identity, go to ISSUE (1-cycle grant latency).
REQ-022 Round-robin: when both requests are high, the client not granted last wins; the pointer after reset favours store.
REQ-023 ISSUE: drive the latched command, addr, data and size; if Dmem2proc_response==0, remain in ISSUE and retry every cycle.
REQ-024 ISSUE, response!=0: latch the response as tag; a store goes to ACK, a load goes to WAIT_DATA.
REQ-025 Outside ISSUE: proc2Dmem_command SHALL be BUS_NONE; addr, data and size hold their latched values.
REQ-026 WAIT_DATA: when Dmem2proc_tag==tag and tag!=0, capture Dmem2proc_data into load_data and go to ACK; a same-cycle mismatched tag is ignored.
REQ-027 ACK: pulse load_ack or store_ack for exactly one cycle to the granted client, then go to IDLE; no grant is made in ACK.
REQ-028 Simultaneous requests in IDLE: exactly one grant; the loser stays pending and is granted in a later IDLE.
REQ-029 flush in IDLE or ISSUE with a load granted: drop the load and return to IDLE with no bus command issued after flush and no ack.
REQ-030 flush in WAIT_DATA, or flush while a load is in ACK: set a squash flag; keep waiting for the tag to drain memory; suppress load_ack; return to IDLE.
REQ-031 Stores ignore flush; they are retired and non-speculative.
REQ-032 load_data holds its value until the next load capture.
REQ-033 At most one outstanding memory transaction at any time.

Reset
REQ-034 Reset low: state=IDLE, tag=0, squash=0, RR pointer=store, all outputs 0, proc2Dmem_command=BUS_NONE.
REQ-035 Reset mid-transaction abandons it; a late Dmem2proc_tag after reset is ignored.

Structure
REQ-036 BUS_COMMAND, MEM_SIZE, FU_MEM_PACKET and the 4-bit memory tag width live in the shared sys_defs package; the FSM state enum is local.
REQ-037 Single module; an optional rr_arbiter2 sub-module holds the two-client round-robin selection.

Verification
REQ-038 Load only, addr 0x100, response=3 on the first ISSUE cycle, tag=3 two cycles later with data 0xDEADBEEF -> load_ack pulses once and load_data=0xDEADBEEF.
REQ-039 Store only, addr 0x200, data 0x55, response 0 for 3 cycles then 5 -> BUS_STORE is held 4 cycles and store_ack pulses the cycle after acceptance.
REQ-040 Both requests in IDLE, RR_ARB=1, back-to-back -> store is granted first, then load; RR_ARB=0 repeated -> store is always granted first.
REQ-041 Load in WAIT_DATA, tag=2, wrong tag 7 arrives, then tag 2 -> only tag 2 captures.
REQ-042 flush in WAIT_DATA, then tag arrives -> no load_ack, return to IDLE, next request is granted normally.
REQ-043 Reset asserted during ISSUE -> outputs 0 immediately and command=BUS_NONE; a later tag produces no ack.
